// File: rtl/axi_burst_mem_pkg.sv
// Shared encodings for the AXI burst memory: burst types, response codes and FSM states.
package axi_burst_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WIdle = 2'd0,
        WData = 2'd1,
        WResp = 2'd2
    } wr_state_e;

    typedef enum logic {
        RIdle = 1'b0,
        RData = 1'b1
    } rd_state_e;

    // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_mem_addr_gen.sv
// Per-beat AXI address generator: captures a burst descriptor, then steps through FIXED,
// INCR or WRAP addresses and flags the final beat.
module axi_burst_addr_gen
    import axi_burst_mem_pkg::*;
#(
    parameter int unsigned MAX_SIZE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  burst_i,
    input  logic        step_i,
    output logic [31:0] addr_o,
    output logic        last_o
);

    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;

    logic [2:0]  size_eff;
    logic [1:0]  burst_eff;
    logic [31:0] step_bytes, aligned, incr_addr, wrap_mask, next_addr;

    // Oversized transfers collapse to the bus width; illegal WRAP lengths and the reserved
    // burst encoding both degrade to INCR.
    always_comb begin
        size_eff  = (size_i > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size_i;
        burst_eff = burst_i;
        if (burst_i == 2'b11) begin
            burst_eff = BURST_INCR;
        end else if (burst_i == BURST_WRAP && !wrap_len_ok(len_i)) begin
            burst_eff = BURST_INCR;
        end
    end

    always_comb begin
        step_bytes = 32'd1 << size_q;
        aligned    = addr_q & ~(step_bytes - 32'd1);
        incr_addr  = aligned + step_bytes;
        wrap_mask  = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        if (load_i) begin
            addr_d  = addr_i;
            len_d   = len_i;
            cnt_d   = 8'd0;
            size_d  = size_eff;
            burst_d = burst_eff;
        end else if (step_i) begin
            addr_d = next_addr;
            cnt_d  = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_INCR;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == len_q);

endmodule

// File: rtl/axi_burst_mem.sv
// AXI4 slave RAM with FIXED/INCR/WRAP bursts, narrow transfers, independent read/write
// channels, a 1-cycle synchronous read and a 2-entry R output buffer.
module axi_burst_mem
    import axi_burst_mem_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_SIZE   = 65536,
    parameter string       INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [31:0]             i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [31:0]             i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_SIZE);
    localparam int unsigned WORDS  = MEM_SIZE / STRB_W;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // ---------------- Write channel ----------------
    wr_state_e         wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0] bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              wdecerr_q, wdecerr_d;
    logic              wlast_err_q, wlast_err_d;
    logic              aw_hs, w_hs, mem_we;
    logic [31:0]       wr_addr;
    logic              wr_last;

    axi_burst_addr_gen #(
        .MAX_SIZE (OFF_W)
    ) u_aw_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (aw_hs),
        .addr_i  (i_awaddr),
        .len_i   (i_awlen),
        .size_i  (i_awsize),
        .burst_i (i_awburst),
        .step_i  (w_hs),
        .addr_o  (wr_addr),
        .last_o  (wr_last)
    );

    always_comb begin
        wr_state_d  = wr_state_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        wdecerr_d   = wdecerr_q;
        wlast_err_d = wlast_err_q;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        mem_we      = 1'b0;
        unique case (wr_state_q)
            WIdle: begin
                if (i_awvalid) begin
                    aw_hs       = 1'b1;
                    bid_d       = i_awid;
                    wdecerr_d   = ({1'b0, i_awaddr} >= 33'(MEM_SIZE));
                    wlast_err_d = 1'b0;
                    wr_state_d  = WData;
                end
            end
            WData: begin
                if (i_wvalid) begin
                    w_hs   = 1'b1;
                    mem_we = !wdecerr_q;
                    if (i_wlast != wr_last) begin
                        wlast_err_d = 1'b1;
                    end
                    // The beat counter, not wlast, decides where the burst ends.
                    if (wr_last) begin
                        wr_state_d = WResp;
                        if (wdecerr_q) begin
                            bresp_d = RESP_DECERR;
                        end else if (wlast_err_d) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            bresp_d = RESP_OKAY;
                        end
                    end
                end
            end
            WResp: begin
                if (i_bready) begin
                    wr_state_d = WIdle;
                end
            end
            default: wr_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q  <= WIdle;
            bid_q       <= '0;
            bresp_q     <= RESP_OKAY;
            wdecerr_q   <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            wdecerr_q   <= wdecerr_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    mem[wr_addr[IDX_W-1:OFF_W]][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_awready = (wr_state_q == WIdle);
    assign o_wready  = (wr_state_q == WData);
    assign o_bvalid  = (wr_state_q == WResp);
    assign o_bid     = bid_q;
    assign o_bresp   = bresp_q;

    // ---------------- Read channel ----------------
    rd_state_e           rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rdecerr_q, rdecerr_d;
    logic                issue_done_q, issue_done_d;
    logic                ar_hs, rd_issue, r_pop;
    logic [31:0]         rd_addr;
    logic                rd_last;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]            fifo_last_q;
    logic                  wptr_q, rptr_q;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    axi_burst_addr_gen #(
        .MAX_SIZE (OFF_W)
    ) u_ar_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ar_hs),
        .addr_i  (i_araddr),
        .len_i   (i_arlen),
        .size_i  (i_arsize),
        .burst_i (i_arburst),
        .step_i  (rd_issue),
        .addr_o  (rd_addr),
        .last_o  (rd_last)
    );

    assign r_pop = o_rvalid && i_rready;

    always_comb begin
        rd_state_d   = rd_state_q;
        rid_d        = rid_q;
        rresp_d      = rresp_q;
        rdecerr_d    = rdecerr_q;
        issue_done_d = issue_done_q;
        ar_hs        = 1'b0;
        rd_issue     = 1'b0;
        unique case (rd_state_q)
            RIdle: begin
                if (i_arvalid) begin
                    ar_hs        = 1'b1;
                    rid_d        = i_arid;
                    rdecerr_d    = ({1'b0, i_araddr} >= 33'(MEM_SIZE));
                    rresp_d      = rdecerr_d ? RESP_DECERR : RESP_OKAY;
                    issue_done_d = 1'b0;
                    rd_state_d   = RData;
                end
            end
            RData: begin
                // Issue only into free buffer space so no beat is ever overwritten.
                if (!issue_done_q && fifo_cnt_q != 2'd2) begin
                    rd_issue = 1'b1;
                    if (rd_last) begin
                        issue_done_d = 1'b1;
                    end
                end
                if (r_pop && o_rlast) begin
                    rd_state_d = RIdle;
                end
            end
            default: rd_state_d = RIdle;
        endcase
        fifo_cnt_d = fifo_cnt_q + {1'b0, rd_issue} - {1'b0, r_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q   <= RIdle;
            rid_q        <= '0;
            rresp_q      <= RESP_OKAY;
            rdecerr_q    <= 1'b0;
            issue_done_q <= 1'b0;
            fifo_last_q  <= '0;
            wptr_q       <= 1'b0;
            rptr_q       <= 1'b0;
            fifo_cnt_q   <= '0;
        end else begin
            rd_state_q   <= rd_state_d;
            rid_q        <= rid_d;
            rresp_q      <= rresp_d;
            rdecerr_q    <= rdecerr_d;
            issue_done_q <= issue_done_d;
            fifo_cnt_q   <= fifo_cnt_d;
            if (rd_issue) begin
                fifo_last_q[wptr_q] <= rd_last;
                wptr_q              <= ~wptr_q;
            end
            if (r_pop) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    // Synchronous RAM read lands directly in the output buffer (read-before-write).
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            fifo_data_q[wptr_q] <= rdecerr_q ? '0 : mem[rd_addr[IDX_W-1:OFF_W]];
        end
    end

    assign o_arready = (rd_state_q == RIdle);
    assign o_rvalid  = (fifo_cnt_q != 2'd0);
    assign o_rdata   = fifo_data_q[rptr_q];
    assign o_rlast   = o_rvalid && fifo_last_q[rptr_q];
    assign o_rid     = rid_q;
    assign o_rresp   = rresp_q;

    logic unused_addr;
    assign unused_addr = ^{wr_addr[31:IDX_W], wr_addr[OFF_W-1:0],
                           rd_addr[31:IDX_W], rd_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_axi_burst_mem.sv
// Directed bench for axi_burst_mem: bursts, narrow writes, backpressure, errors, reset.
module tb_axi_burst_mem;

    localparam int unsigned IDW = 4;
    localparam int unsigned DW  = 64;
    localparam int unsigned MS  = 65536;

    logic           clk, rst_n;
    logic [IDW-1:0] i_awid, i_arid;
    logic [31:0]    i_awaddr, i_araddr;
    logic [7:0]     i_awlen, i_arlen;
    logic [2:0]     i_awsize, i_arsize;
    logic [1:0]     i_awburst, i_arburst;
    logic           i_awvalid, o_awready, i_arvalid, o_arready;
    logic [DW-1:0]  i_wdata;
    logic [DW/8-1:0] i_wstrb;
    logic           i_wlast, i_wvalid, o_wready;
    logic [IDW-1:0] o_bid, o_rid;
    logic [1:0]     o_bresp, o_rresp;
    logic           o_bvalid, i_bready;
    logic [DW-1:0]  o_rdata;
    logic           o_rlast, o_rvalid, i_rready;

    int total = 0;
    int bad   = 0;

    logic [63:0] rdat [$];
    logic        rlst [$];
    logic [1:0]  rrsp [$];
    logic [63:0] exp_q [$];

    axi_burst_mem #(
        .ID_WIDTH   (IDW),
        .DATA_WIDTH (DW),
        .MEM_SIZE   (MS),
        .INIT_FILE  ("")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_awid    (i_awid),
        .i_awaddr  (i_awaddr),
        .i_awlen   (i_awlen),
        .i_awsize  (i_awsize),
        .i_awburst (i_awburst),
        .i_awvalid (i_awvalid),
        .o_awready (o_awready),
        .i_arid    (i_arid),
        .i_araddr  (i_araddr),
        .i_arlen   (i_arlen),
        .i_arsize  (i_arsize),
        .i_arburst (i_arburst),
        .i_arvalid (i_arvalid),
        .o_arready (o_arready),
        .i_wdata   (i_wdata),
        .i_wstrb   (i_wstrb),
        .i_wlast   (i_wlast),
        .i_wvalid  (i_wvalid),
        .o_wready  (o_wready),
        .o_bid     (o_bid),
        .o_bresp   (o_bresp),
        .o_bvalid  (o_bvalid),
        .i_bready  (i_bready),
        .o_rid     (o_rid),
        .o_rdata   (o_rdata),
        .o_rresp   (o_rresp),
        .o_rlast   (o_rlast),
        .o_rvalid  (o_rvalid),
        .i_rready  (i_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cyc = 0;
        @(negedge clk);
        i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
        i_awvalid = 1'b1;
        while (!o_awready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!o_awready) check("aw_timeout", 64'(o_awready), 64'd1);
        @(posedge clk);
        #1 i_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int cyc = 0;
        @(negedge clk);
        i_wdata = data; i_wstrb = strb; i_wlast = last; i_wvalid = 1'b1;
        while (!o_wready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!o_wready) check("w_timeout", 64'(o_wready), 64'd1);
        @(posedge clk);
        #1 i_wvalid = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [1:0] resp, input logic [3:0] id);
        int cyc = 0;
        @(negedge clk);
        i_bready = 1'b1;
        while (!o_bvalid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_bvalid"}, 64'(o_bvalid), 64'd1);
        check({tag, "_bresp"}, 64'(o_bresp), 64'(resp));
        check({tag, "_bid"}, 64'(o_bid), 64'(id));
        @(posedge clk);
        #1 i_bready = 1'b0;
    endtask

    // Beat i carries base+i; wlast_ok=0 inverts wlast on every beat.
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [63:0] base, input logic [7:0] strb, input bit wlast_ok);
        aw_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            w_send(base + 64'(i), strb, (i == int'(len)) ~^ wlast_ok);
        end
    endtask

    task automatic r_collect(input int n, input bit toggle);
        int cyc = 0;
        rdat.delete(); rlst.delete(); rrsp.delete();
        while (rdat.size() < n && cyc < 300) begin
            @(negedge clk);
            i_rready = toggle ? ~i_rready : 1'b1;
            if (o_rvalid && i_rready) begin
                rdat.push_back(o_rdata);
                rlst.push_back(o_rlast);
                rrsp.push_back(o_rresp);
            end
            cyc++;
        end
        @(posedge clk);
        #1 i_rready = 1'b0;
        if (rdat.size() < n) check("r_timeout", 64'(rdat.size()), 64'(n));
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cyc = 0;
        @(negedge clk);
        i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
        i_arvalid = 1'b1;
        while (!o_arready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!o_arready) check("ar_timeout", 64'(o_arready), 64'd1);
        @(posedge clk);
        #1 i_arvalid = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [1:0] resp, input logic [3:0] id);
        int n;
        n = (rdat.size() < exp_q.size()) ? rdat.size() : exp_q.size();
        check({tag, "_beats"}, 64'(rdat.size()), 64'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), rdat[i], exp_q[i]);
            check($sformatf("%s_last%0d", tag, i), 64'(rlst[i]), 64'(i == exp_q.size() - 1));
            check($sformatf("%s_resp%0d", tag, i), 64'(rrsp[i]), 64'(resp));
        end
        check({tag, "_rid"}, 64'(o_rid), 64'(id));
        repeat (3) @(negedge clk);
        check({tag, "_no_extra"}, 64'(o_rvalid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0;
        i_bready = 1'b0; i_rready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_awready", 64'(o_awready), 64'd1);
        check("rst_arready", 64'(o_arready), 64'd1);
        check("rst_wready", 64'(o_wready), 64'd0);
        check("rst_bvalid", 64'(o_bvalid), 64'd0);
        check("rst_rvalid", 64'(o_rvalid), 64'd0);
        check("rst_rlast", 64'(o_rlast), 64'd0);
        check("rst_bresp", 64'(o_bresp), 64'd0);
        check("rst_rresp", 64'(o_rresp), 64'd0);
        check("rst_bid", 64'(o_bid), 64'd0);
        check("rst_rid", 64'(o_rid), 64'd0);

        // INCR write 1..4 at 0x100, then read back with first-beat latency check.
        write_burst(4'd5, 32'h100, 8'd3, 3'd3, 2'b01, 64'd1, 8'hFF, 1'b1);
        b_recv("incr_wr", 2'b00, 4'd5);
        ar_send(4'd3, 32'h100, 8'd3, 3'd3, 2'b01);
        @(negedge clk);
        check("lat_n1_rvalid", 64'(o_rvalid), 64'd0);
        @(negedge clk);
        check("lat_n2_rvalid", 64'(o_rvalid), 64'd1);
        r_collect(4, 1'b0);
        exp_q = '{64'd1, 64'd2, 64'd3, 64'd4};
        check_read("incr_rd", 2'b00, 4'd3);

        // WRAP from 0x118 over a 32-byte window.
        ar_send(4'd7, 32'h118, 8'd3, 3'd3, 2'b10);
        r_collect(4, 1'b0);
        exp_q = '{64'd4, 64'd1, 64'd2, 64'd3};
        check_read("wrap_rd", 2'b00, 4'd7);

        // FIXED stays on 0x108.
        ar_send(4'd2, 32'h108, 8'd1, 3'd3, 2'b00);
        r_collect(2, 1'b0);
        exp_q = '{64'd2, 64'd2};
        check_read("fixed_rd", 2'b00, 4'd2);

        // Narrow byte write into byte lane 3 of word 0x200.
        write_burst(4'd1, 32'h200, 8'd0, 3'd3, 2'b01, 64'h0706_0504_0302_0100, 8'hFF, 1'b1);
        b_recv("pre_narrow", 2'b00, 4'd1);
        write_burst(4'd1, 32'h203, 8'd0, 3'd0, 2'b01, 64'h5555_5555_AB55_5555, 8'h08, 1'b1);
        b_recv("narrow_wr", 2'b00, 4'd1);
        ar_send(4'd1, 32'h200, 8'd0, 3'd3, 2'b01);
        r_collect(1, 1'b0);
        exp_q = '{64'h0706_0504_AB02_0100};
        check_read("narrow_rd", 2'b00, 4'd1);

        // 8-beat read under alternating backpressure.
        write_burst(4'd4, 32'h300, 8'd7, 3'd3, 2'b01, 64'h1000, 8'hFF, 1'b1);
        b_recv("len8_wr", 2'b00, 4'd4);
        ar_send(4'd9, 32'h300, 8'd7, 3'd3, 2'b01);
        r_collect(8, 1'b1);
        exp_q = '{64'h1000, 64'h1001, 64'h1002, 64'h1003,
                  64'h1004, 64'h1005, 64'h1006, 64'h1007};
        check_read("toggle_rd", 2'b00, 4'd9);

        // DECERR write must not alias onto word 0.
        write_burst(4'd6, 32'h0, 8'd1, 3'd3, 2'b01, 64'hA0, 8'hFF, 1'b1);
        b_recv("pre_dec", 2'b00, 4'd6);
        write_burst(4'd8, MS, 8'd1, 3'd3, 2'b01, 64'hD0, 8'hFF, 1'b1);
        b_recv("dec_wr", 2'b11, 4'd8);
        ar_send(4'd6, 32'h0, 8'd1, 3'd3, 2'b01);
        r_collect(2, 1'b0);
        exp_q = '{64'hA0, 64'hA1};
        check_read("dec_mem", 2'b00, 4'd6);
        ar_send(4'd10, MS, 8'd0, 3'd3, 2'b01);
        r_collect(1, 1'b0);
        exp_q = '{64'd0};
        check_read("dec_rd", 2'b11, 4'd10);

        // wlast on the wrong beats: SLVERR, data still written.
        write_burst(4'd11, 32'h500, 8'd1, 3'd3, 2'b01, 64'hE0, 8'hFF, 1'b0);
        b_recv("slverr_wr", 2'b10, 4'd11);
        ar_send(4'd11, 32'h500, 8'd1, 3'd3, 2'b01);
        r_collect(2, 1'b0);
        exp_q = '{64'hE0, 64'hE1};
        check_read("slverr_rd", 2'b00, 4'd11);

        // Reset while beat 2 of 4 is on the bus.
        aw_send(4'd12, 32'h400, 8'd3, 3'd3, 2'b01);
        w_send(64'hC0, 8'hFF, 1'b0);
        w_send(64'hC1, 8'hFF, 1'b0);
        @(negedge clk);
        i_wdata = 64'hC2; i_wstrb = 8'hFF; i_wlast = 1'b0; i_wvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_awready", 64'(o_awready), 64'd1);
        check("mid_rst_wready", 64'(o_wready), 64'd0);
        i_wvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_bvalid", 64'(o_bvalid), 64'd0);
        check("post_rst_awready", 64'(o_awready), 64'd1);
        ar_send(4'd13, 32'h400, 8'd1, 3'd3, 2'b01);
        r_collect(2, 1'b0);
        exp_q = '{64'hC0, 64'hC1};
        check_read("rst_rd", 2'b00, 4'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
